// File: rtl/pci_reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pci_reset_sequencer_pkg
//  Description : Shared constants for the PCI reset sequencer: state
//                encodings, their 3-bit width and the sequencing counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pci_reset_sequencer_pkg;

    localparam int SEQ_STATE_W = 3;

    // Counter must span LOCK_TIMEOUT-1 and DRIVE_CYCLES-1 (up to 65535)
    // and STAGGER_CYCLES*NUM_DOMAINS (up to 2048).
    localparam int SEQ_CNT_W = 17;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_DRIVE     = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/pci_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pci_reset_sequencer_if
//  Description : Pad, PLL, software request and reset-domain signals of the
//                PCI reset sequencer. slave = sequencer side, master = the
//                environment driving it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pci_reset_sequencer_if
    import pci_reset_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS = 4
);
    logic                   pci_reset_in_l;
    logic                   pll_locked;
    logic                   sw_reset_req;
    logic [NUM_DOMAINS-1:0] domain_reset;
    logic                   pci_reset_out_oe;
    logic                   reset_done;
    logic                   lock_timeout;
    logic [SEQ_STATE_W-1:0] seq_state;

    modport slave (
        input  pci_reset_in_l, pll_locked, sw_reset_req,
        output domain_reset, pci_reset_out_oe, reset_done, lock_timeout, seq_state
    );

    modport master (
        output pci_reset_in_l, pll_locked, sw_reset_req,
        input  domain_reset, pci_reset_out_oe, reset_done, lock_timeout, seq_state
    );
endinterface
`default_nettype wire

// File: rtl/pci_reset_filter.sv
`default_nettype none
// ============================================================================
//  Module      : pci_reset_filter
//  Description : Two-flop synchronizer plus persistence filter for the raw
//                active-low PCI pad reset. ext_rst_o (active high) only
//                changes after FILTER_CYCLES consecutive synchronized samples
//                of the opposite level.
//  Revision    : 1.0 - initial release
// ============================================================================
module pci_reset_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  wire logic pci_clk,
    input  wire logic pci_reset,
    input  wire logic rst_in_l_i,
    output logic      ext_rst_o
);
    localparam int CNT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(FILTER_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             ext_rst_q;
    logic [CNT_W-1:0] cnt_q;
    logic             w_raw_rst;

    // Synchronize the pad; flops come out of reset showing an asserted pad.
    always_ff @(posedge pci_clk) begin
        if (pci_reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= rst_in_l_i;
            sync_q <= meta_q;
        end
    end

    assign w_raw_rst = ~sync_q;

    // Count consecutive disagreeing samples; flip once the run is long enough.
    always_ff @(posedge pci_clk) begin
        if (pci_reset) begin
            ext_rst_q <= 1'b1;
            cnt_q     <= '0;
        end else if (w_raw_rst != ext_rst_q) begin
            if (cnt_q == c_cnt_last) begin
                ext_rst_q <= w_raw_rst;
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign ext_rst_o = ext_rst_q;
endmodule
`default_nettype wire

// File: rtl/pci_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pci_reset_sequencer
//  Description : PCI reset sequencer. Filters the pad reset, waits for PLL
//                lock (with timeout), releases downstream reset domains in a
//                staggered order and optionally drives a software bus reset.
//                Optional feature macro: PCI_RESET_SW_DRIVE_EN enables the
//                DRIVE state and the sw_reset_req path.
//  Revision    : 1.0 - initial release
// ============================================================================
module pci_reset_sequencer
    import pci_reset_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS    = 4,
    parameter int FILTER_CYCLES  = 4,
    parameter int LOCK_TIMEOUT   = 1024,
    parameter int STAGGER_CYCLES = 8,
    parameter int DRIVE_CYCLES   = 64
) (
    input  wire logic             pci_clk,
    input  wire logic             pci_reset,
    pci_reset_sequencer_if.slave  bus
);
    localparam logic [SEQ_CNT_W-1:0] c_lock_last    = SEQ_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [SEQ_CNT_W-1:0] c_release_last = SEQ_CNT_W'(STAGGER_CYCLES * NUM_DOMAINS - 1);
    localparam logic [SEQ_CNT_W-1:0] c_drive_last   = SEQ_CNT_W'(DRIVE_CYCLES - 1);

    seq_state_t             state_q, state_d;
    logic [SEQ_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   lock_timeout_q, lock_timeout_d;
    logic [NUM_DOMAINS-1:0] domain_reset_q, domain_reset_d;
    logic                   lock_meta_q, lock_sync_q;
    logic                   w_ext_rst;
    logic                   w_sw_req;

    pci_reset_filter #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_ext_filter (
        .pci_clk    (pci_clk),
        .pci_reset  (pci_reset),
        .rst_in_l_i (bus.pci_reset_in_l),
        .ext_rst_o  (w_ext_rst)
    );

    // Plain two-flop synchronizer for PLL lock; reads unlocked out of reset.
    always_ff @(posedge pci_clk) begin
        if (pci_reset) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= bus.pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

`ifdef PCI_RESET_SW_DRIVE_EN
    logic oe_q;

    assign w_sw_req = bus.sw_reset_req;

    // Pad output enable follows DRIVE one-for-one, registered.
    always_ff @(posedge pci_clk) begin
        if (pci_reset) begin
            oe_q <= 1'b0;
        end else begin
            oe_q <= (state_d == ST_DRIVE);
        end
    end

    assign bus.pci_reset_out_oe = oe_q;
`else
    logic unused_sw_reset_req;

    assign unused_sw_reset_req  = bus.sw_reset_req;
    assign w_sw_req             = 1'b0;
    assign bus.pci_reset_out_oe = 1'b0;
`endif

    // Next-state, shared counter and next domain reset pattern.
    always_comb begin
        state_d        = state_q;
        lock_timeout_d = lock_timeout_q;
        cnt_d          = '0;
        domain_reset_d = '1;

        unique case (state_q)
            ST_HOLD: begin
                if (!w_ext_rst) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_ext_rst) begin
                    state_d = ST_HOLD;
                end else if (lock_sync_q) begin
                    state_d = ST_RELEASE;
                end else if (cnt_q == c_lock_last) begin
                    state_d        = ST_RELEASE;
                    lock_timeout_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (w_ext_rst) begin
                    state_d = ST_HOLD;
                end else if (cnt_q == c_release_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Pad reset outranks a software request, which outranks lock loss.
                if (w_ext_rst) begin
                    state_d = ST_HOLD;
                end else if (w_sw_req) begin
                    state_d = ST_DRIVE;
                end else if (!lock_sync_q && !lock_timeout_q) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_DRIVE: begin
                // Looped-back pad reset is deliberately ignored while driving.
                if (cnt_q == c_drive_last) state_d = ST_HOLD;
            end
            default: state_d = ST_HOLD;
        endcase

        // Counter restarts on every state entry and only runs where it is timed.
        if (state_d == state_q &&
            (state_q == ST_WAIT_LOCK || state_q == ST_RELEASE || state_q == ST_DRIVE)) begin
            cnt_d = cnt_q + 1'b1;
        end

        for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (state_d == ST_RELEASE) begin
                domain_reset_d[k] = (cnt_d < SEQ_CNT_W'(STAGGER_CYCLES * (k + 1)));
            end else begin
                domain_reset_d[k] = (state_d != ST_RUN);
            end
        end
    end

    // State register plus registered domain resets and sticky timeout flag.
    always_ff @(posedge pci_clk) begin
        if (pci_reset) begin
            state_q        <= ST_HOLD;
            cnt_q          <= '0;
            lock_timeout_q <= 1'b0;
            domain_reset_q <= '1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lock_timeout_q <= lock_timeout_d;
            domain_reset_q <= domain_reset_d;
        end
    end

    assign bus.domain_reset = domain_reset_q;
    assign bus.reset_done   = (state_q == ST_RUN);
    assign bus.lock_timeout = lock_timeout_q;
    assign bus.seq_state    = state_q;
endmodule
`default_nettype wire
